// File: rtl/traductor_bcd_secuencial_if.sv
// traductor_bcd_secuencial_if: start/ready handshake and result bus of the BCD converter
interface traductor_bcd_secuencial_if #(
    parameter int ANCHO   = 16,
    parameter int DIGITOS = 5
);
    logic                   inicio;
    logic [ANCHO-1:0]       cuenta;
    logic                   ocupado;
    logic                   listo;
    logic [4*DIGITOS-1:0]   digitos;
    logic                   desborde;
    modport master (output inicio, cuenta, input ocupado, listo, digitos, desborde);
    modport slave  (input inicio, cuenta, output ocupado, listo, digitos, desborde);
endinterface

// File: rtl/traductor_bcd_secuencial.sv
// traductor_bcd_secuencial: multi-cycle double-dabble binary to BCD converter
module traductor_bcd_secuencial #(
    parameter int ANCHO   = 16,
    parameter int DIGITOS = 5
) (
    input  logic clk,
    input  logic rst_n,
    traductor_bcd_secuencial_if.slave bus
);
    localparam int CW = $clog2(ANCHO + 1);
    typedef enum logic [1:0] {REPOSO, DESPLAZA, FIN} estado_t;
    estado_t              estado_q;
    logic [ANCHO-1:0]     desp_q;
    logic [4*DIGITOS-1:0] bcd_q;
    logic [4*DIGITOS-1:0] ajustado_d;
    logic [4*DIGITOS-1:0] digitos_q;
    logic [CW-1:0]        cnt_q;
    logic                 ovf_q;
    logic                 ocupado_q;
    logic                 listo_q;
    logic                 desborde_q;
    // Per-digit add-3 correction; each digit is a separate 4-bit add with no carry between digits
    for (genvar i = 0; i < DIGITOS; i++) begin : g_ajuste
        assign ajustado_d[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    end
    // Control FSM: capture, one shift per edge, then publish the result with a Listo pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= REPOSO;
            desp_q     <= '0;
            bcd_q      <= '0;
            digitos_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (bus.inicio) begin
                        desp_q    <= bus.cuenta;
                        bcd_q     <= '0;
                        ovf_q     <= 1'b0;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= DESPLAZA;
                    end
                end
                DESPLAZA: begin
                    bcd_q  <= {ajustado_d[4*DIGITOS-2:0], desp_q[ANCHO-1]};
                    desp_q <= desp_q << 1;
                    ovf_q  <= ovf_q | ajustado_d[4*DIGITOS-1];
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ANCHO - 1)) estado_q <= FIN;
                end
                FIN: begin
                    digitos_q  <= bcd_q;
                    desborde_q <= ovf_q;
                    listo_q    <= 1'b1;
                    ocupado_q  <= 1'b0;
                    estado_q   <= REPOSO;
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end
    assign bus.ocupado  = ocupado_q;
    assign bus.listo    = listo_q;
    assign bus.digitos  = digitos_q;
    assign bus.desborde = desborde_q;
endmodule

// File: tb/tb_traductor_bcd_secuencial.sv
// tb_traductor_bcd_secuencial: randomized checks of the BCD converter against an arithmetic model
module tb_traductor_bcd_secuencial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    traductor_bcd_secuencial_if #(.ANCHO(16), .DIGITOS(5)) b ();
    traductor_bcd_secuencial_if #(.ANCHO(16), .DIGITOS(4)) b4 ();
    traductor_bcd_secuencial_if #(.ANCHO(5), .DIGITOS(2)) b5 ();
    traductor_bcd_secuencial #(.ANCHO(16), .DIGITOS(5)) dut  (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    traductor_bcd_secuencial #(.ANCHO(16), .DIGITOS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    traductor_bcd_secuencial #(.ANCHO(5), .DIGITOS(2))  dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    // Reference: decimal digits of v, lowest d digits, by repeated division
    function automatic logic [39:0] ref_bcd(input longint v, input int d);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint v, input int d);
        longint p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return v >= p;
    endfunction

    // Start a conversion and return the accepting-edge-inclusive latency (posedges) to Listo
    task automatic run_main(input logic [15:0] v, output int e);
        @(negedge clk); b.cuenta = v; b.inicio = 1'b1;
        @(posedge clk); #1 b.inicio = 1'b0; e = 1;
        while (!b.listo && e < 60) begin @(posedge clk); #1 e++; end
    endtask

    task automatic run_b4(input logic [15:0] v, output int e);
        @(negedge clk); b4.cuenta = v; b4.inicio = 1'b1;
        @(posedge clk); #1 b4.inicio = 1'b0; e = 1;
        while (!b4.listo && e < 60) begin @(posedge clk); #1 e++; end
    endtask

    task automatic run_b5(input logic [4:0] v, output int e);
        @(negedge clk); b5.cuenta = v; b5.inicio = 1'b1;
        @(posedge clk); #1 b5.inicio = 1'b0; e = 1;
        while (!b5.listo && e < 60) begin @(posedge clk); #1 e++; end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({b.ocupado, b.listo, b.digitos, b.desborde} !== '0) begin
            errors++; $display("FAIL reset_state: got ocupado=%b listo=%b digitos=%h desborde=%b, want all 0", b.ocupado, b.listo, b.digitos, b.desborde);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_max();
        @(negedge clk); b.cuenta = 16'd65535; b.inicio = 1'b1;
        @(posedge clk); #1 b.inicio = 1'b0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (b.ocupado !== 1'b1 || b.listo !== 1'b0) begin
                errors++; $display("FAIL max_busy[%0d]: got ocupado=%b listo=%b, want 1 0", i, b.ocupado, b.listo);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (b.listo !== 1'b1 || b.ocupado !== 1'b0 || b.digitos !== 20'h65535 || b.desborde !== 1'b0) begin
            errors++; $display("FAIL max_result: got listo=%b ocupado=%b digitos=%h desborde=%b, want 1 0 65535 0", b.listo, b.ocupado, b.digitos, b.desborde);
        end
        @(posedge clk); #1;
        checks++;
        if (b.listo !== 1'b0 || b.digitos !== 20'h65535) begin
            errors++; $display("FAIL max_hold: got listo=%b digitos=%h, want 0 65535", b.listo, b.digitos);
        end
    endtask

    task automatic test_random();
        int e;
        logic [15:0] v;
        for (int n = 0; n < 30; n++) begin
            v = 16'($urandom);
            run_main(v, e);
            checks++;
            if (e !== 18 || b.digitos !== ref_bcd(v, 5)[19:0] || b.desborde !== ref_ovf(v, 5)) begin
                errors++; $display("FAIL random %0d: got lat=%0d digitos=%h desborde=%b, want 18 %h %b", v, e, b.digitos, b.desborde, ref_bcd(v, 5)[19:0], ref_ovf(v, 5));
            end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge clk); b.cuenta = 16'd0; b.inicio = 1'b1;
        @(posedge clk); #1 e = 1;
        while (!b.listo && e < 60) begin @(posedge clk); #1 e++; end
        checks++;
        if (e !== 18 || b.digitos !== 20'h00000) begin
            errors++; $display("FAIL b2b_first: got lat=%0d digitos=%h, want 18 00000", e, b.digitos);
        end
        b.cuenta = 16'd10009;
        @(posedge clk); #1 b.inicio = 1'b0; e = 1;
        checks++;
        if (b.ocupado !== 1'b1 || b.listo !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got ocupado=%b listo=%b, want 1 0", b.ocupado, b.listo);
        end
        while (!b.listo && e < 60) begin @(posedge clk); #1 e++; end
        checks++;
        if (e !== 18 || b.digitos !== 20'h10009 || b.desborde !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got lat=%0d digitos=%h desborde=%b, want 18 10009 0", e, b.digitos, b.desborde);
        end
    endtask

    task automatic test_busy();
        int pulses;
        @(negedge clk); b.cuenta = 16'd500; b.inicio = 1'b1;
        @(posedge clk); #1 b.inicio = 1'b0;
        pulses = 0;
        for (int i = 1; i < 40; i++) begin
            if (i == 5) begin b.cuenta = 16'd777; b.inicio = 1'b1; end
            if (i == 6) b.inicio = 1'b0;
            @(posedge clk); #1;
            if (b.listo) pulses++;
            if (b.listo && i == 17) b.cuenta = 16'd777;
        end
        checks++;
        if (pulses !== 1 || b.digitos !== 20'h00500) begin
            errors++; $display("FAIL busy: got pulses=%0d digitos=%h, want 1 00500", pulses, b.digitos);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int pulses;
        @(negedge clk); b.cuenta = 16'd4321; b.inicio = 1'b1;
        @(posedge clk); #1 b.inicio = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({b.ocupado, b.listo, b.digitos, b.desborde} !== '0) begin
            errors++; $display("FAIL reset_mid: got ocupado=%b listo=%b digitos=%h desborde=%b, want all 0", b.ocupado, b.listo, b.digitos, b.desborde);
        end
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin @(posedge clk); #1 if (b.listo) pulses++; end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL reset_no_listo: got pulses=%0d, want 0", pulses);
        end
        run_main(16'd4321, e);
        checks++;
        if (e !== 18 || b.digitos !== 20'h04321) begin
            errors++; $display("FAIL reset_recover: got lat=%0d digitos=%h, want 18 04321", e, b.digitos);
        end
    endtask

    task automatic test_overflow();
        int e;
        logic [15:0] v;
        logic [15:0] vals [2] = '{16'd12345, 16'd9999};
        for (int n = 0; n < 12; n++) begin
            v = (n < 2) ? vals[n] : 16'($urandom);
            run_b4(v, e);
            checks++;
            if (e !== 18 || b4.digitos !== ref_bcd(v, 4)[15:0] || b4.desborde !== ref_ovf(v, 4)) begin
                errors++; $display("FAIL overflow %0d: got lat=%0d digitos=%h desborde=%b, want 18 %h %b", v, e, b4.digitos, b4.desborde, ref_bcd(v, 4)[15:0], ref_ovf(v, 4));
            end
        end
    endtask

    task automatic test_exhaustive();
        int e;
        for (int v = 0; v < 32; v++) begin
            run_b5(5'(v), e);
            checks++;
            if (e !== 7 || b5.digitos !== ref_bcd(v, 2)[7:0] || b5.desborde !== 1'b0) begin
                errors++; $display("FAIL narrow %0d: got lat=%0d digitos=%h desborde=%b, want 7 %h 0", v, e, b5.digitos, b5.desborde, ref_bcd(v, 2)[7:0]);
            end
        end
    endtask

    initial begin
        b.inicio = 1'b0; b.cuenta = '0;
        b4.inicio = 1'b0; b4.cuenta = '0;
        b5.inicio = 1'b0; b5.cuenta = '0;
        test_reset();
        test_max();
        test_random();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_overflow();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
